// File: rtl/alu_writeback_if.sv
// alu_writeback_if: ALU-result bus into the writeback stage, plus the shared flag/control types.
//   types::flags_t  - architectural flags {S, Z, C, V}
//   types::ctl_t    - per-flag commit enables {C, Z, S, V}
//   master modport  - producer (ALU side): drives in_valid and in_* fields, sees in_ready
//   slave modport   - writeback stage: sees in_valid and in_* fields, drives in_ready
package types;
   typedef struct packed {
      logic s;
      logic z;
      logic c;
      logic v;
   } flags_t;
   typedef struct packed {
      logic c;
      logic z;
      logic s;
      logic v;
   } ctl_t;
endpackage

interface alu_writeback_if #(
   parameter int width = 8,
   parameter int nregs = 4
);
   localparam int aw = $clog2(nregs);
   logic               in_valid;
   logic               in_ready;
   logic [width-1:0]   in_data;
   types::flags_t      in_flags;
   types::ctl_t        in_fmask;
   logic [aw-1:0]      in_rd;
   logic               in_we;
   modport master (output in_valid, in_data, in_flags, in_fmask, in_rd, in_we, input in_ready);
   modport slave (input in_valid, in_data, in_flags, in_fmask, in_rd, in_we, output in_ready);
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: execute-to-writeback stage; one pipeline register committing into a register file and flag register.
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_bus            - ALU result handshake (valid/ready, data, flags, flag mask, rd, we)
//   wb_stall          - hold the stage register and suppress commit
//   rs1/rs2, rdata1/2 - bypassed register reads (combinational)
//   flags             - bypassed flags for the ALU flag input (combinational)
//   commit_valid/rd/data - trace of the entry committing on this edge
module alu_writeback #(
   parameter int width = 8,
   parameter int nregs = 4,
   localparam int aw = $clog2(nregs)
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_writeback_if.slave   in_bus,
   input  logic             wb_stall,
   input  logic [aw-1:0]    rs1,
   input  logic [aw-1:0]    rs2,
   output logic [width-1:0] rdata1,
   output logic [width-1:0] rdata2,
   output types::flags_t    flags,
   output logic             commit_valid,
   output logic [aw-1:0]    commit_rd,
   output logic [width-1:0] commit_data
);
   logic             valid_q;
   logic             we_q;
   logic [width-1:0] data_q;
   logic [aw-1:0]    rd_q;
   types::flags_t    flags_q;
   types::flags_t    fmask_q;
   types::flags_t    freg;
   types::flags_t    fmask_in;
   types::flags_t    merged;
   logic [width-1:0] rf [nregs];
   logic             accept;
   logic             commit;
   // mask is reordered into flags_t bit order so the merge is a plain bitwise select
   assign fmask_in = '{s: in_bus.in_fmask.s, z: in_bus.in_fmask.z, c: in_bus.in_fmask.c, v: in_bus.in_fmask.v};
   assign merged = types::flags_t'((fmask_q & flags_q) | (~fmask_q & freg));
   assign commit = valid_q && !wb_stall;
   assign in_bus.in_ready = !valid_q || !wb_stall;
   assign accept = in_bus.in_valid && in_bus.in_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         data_q  <= '0;
         rd_q    <= '0;
         flags_q <= '0;
         fmask_q <= '0;
         freg    <= '0;
         for (int i = 0; i < nregs; i++) rf[i] <= '0;
      end else begin
         if (commit) begin
            if (we_q) rf[rd_q] <= data_q;
            freg <= merged;
         end
         if (accept) begin
            valid_q <= 1'b1;
            we_q    <= in_bus.in_we;
            data_q  <= in_bus.in_data;
            rd_q    <= in_bus.in_rd;
            flags_q <= in_bus.in_flags;
            fmask_q <= fmask_in;
         end else if (commit) begin
            valid_q <= 1'b0;
         end
      end
   end
   // the pending entry shadows the register file and flag register, even while stalled
   assign rdata1 = (valid_q && we_q && rd_q == rs1) ? data_q : rf[rs1];
   assign rdata2 = (valid_q && we_q && rd_q == rs2) ? data_q : rf[rs2];
   assign flags = valid_q ? merged : freg;
   assign commit_valid = commit;
   assign commit_rd = rd_q;
   assign commit_data = data_q;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenarios plus randomized traffic against a queue-based model of the writeback stage.
module tb_alu_writeback;
   localparam int width = 8;
   localparam int nregs = 4;
   localparam int aw = 2;
   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             wb_stall = 1'b0;
   logic [aw-1:0]    rs1 = '0;
   logic [aw-1:0]    rs2 = '0;
   logic [width-1:0] rdata1;
   logic [width-1:0] rdata2;
   types::flags_t    flags;
   logic             commit_valid;
   logic [aw-1:0]    commit_rd;
   logic [width-1:0] commit_data;
   int checks = 0;
   int failures = 0;
   alu_writeback_if #(.width(width), .nregs(nregs)) bus ();
   alu_writeback #(.width(width), .nregs(nregs)) dut (
      .clk(clk), .rst_n(rst_n), .in_bus(bus), .wb_stall(wb_stall),
      .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2), .flags(flags),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data)
   );
   always #5 clk = ~clk;
   // model: committed state plus a queue of at most one in-flight entry; flags held as {S,Z,C,V}
   typedef struct {
      logic [width-1:0] data;
      logic [3:0]       fl;
      logic [3:0]       mask;
      logic [aw-1:0]    rd;
      logic             we;
   } ent_t;
   ent_t             pend[$];
   logic [width-1:0] m_rf [nregs];
   logic [3:0]       m_freg;
   function automatic logic [width-1:0] exp_rd(logic [aw-1:0] rs);
      if (pend.size() != 0 && pend[0].we && pend[0].rd == rs) return pend[0].data;
      return m_rf[rs];
   endfunction
   function automatic logic [3:0] exp_fl();
      logic [3:0] r = m_freg;
      if (pend.size() != 0)
         for (int i = 0; i < 4; i++) if (pend[0].mask[i]) r[i] = pend[0].fl[i];
      return r;
   endfunction
   task automatic model_reset();
      pend.delete();
      for (int i = 0; i < nregs; i++) m_rf[i] = '0;
      m_freg = '0;
   endtask
   // ctl is given in {C,Z,S,V} order as the port defines it
   task automatic drive(input logic iv, input logic [width-1:0] d, input logic [3:0] fl,
                        input logic [3:0] ctl, input logic [aw-1:0] rd, input logic we);
      bus.in_valid = iv;
      bus.in_data = d;
      bus.in_flags = types::flags_t'(fl);
      bus.in_fmask = types::ctl_t'(ctl);
      bus.in_rd = rd;
      bus.in_we = we;
   endtask
   task automatic tick();
      logic com;
      logic acc;
      ent_t e;
      @(posedge clk);
      com = pend.size() != 0 && !wb_stall;
      acc = bus.in_valid && (pend.size() == 0 || !wb_stall);
      if (com) begin
         e = pend.pop_front();
         if (e.we) m_rf[e.rd] = e.data;
         for (int i = 0; i < 4; i++) if (e.mask[i]) m_freg[i] = e.fl[i];
      end
      if (acc) begin
         e.data = bus.in_data;
         e.fl = bus.in_flags;
         e.mask = {bus.in_fmask.s, bus.in_fmask.z, bus.in_fmask.c, bus.in_fmask.v};
         e.rd = bus.in_rd;
         e.we = bus.in_we;
         pend.push_back(e);
      end
      #1;
   endtask
   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'($urandom), 4'($urandom), 4'($urandom), 2'(i), 1'b1);
         tick();
      end
      drive(1'b1, 8'h5a, 4'hf, 4'hf, 2'd1, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit got=%b exp=0", commit_valid); end
      checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", flags); end
      #1;
      rst_n = 1'b1;
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      for (int i = 0; i < nregs; i++) begin
         rs1 = 2'(i);
         rs2 = 2'(nregs - 1 - i);
         #1;
         checks++; if (rdata1 !== 8'h00 || rdata2 !== 8'h00) begin failures++; $display("FAIL reset_rdata r%0d got=%h/%h exp=00/00", i, rdata1, rdata2); end
      end
      tick();
      checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_no_pulse got=%b exp=0", commit_valid); end
   endtask
   task automatic test_write_bypass();
      rs1 = 2'd2;
      drive(1'b1, 8'ha5, 4'h0, 4'h0, 2'd2, 1'b1);
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      #1;
      checks++; if (rdata1 !== 8'ha5) begin failures++; $display("FAIL wb_bypass got=%h exp=a5", rdata1); end
      checks++; if (commit_valid !== 1'b1 || commit_rd !== 2'd2 || commit_data !== 8'ha5) begin
         failures++; $display("FAIL wb_commit got=%b/%0d/%h exp=1/2/a5", commit_valid, commit_rd, commit_data); end
      tick();
      checks++; if (commit_valid !== 1'b0 || rdata1 !== 8'ha5) begin failures++; $display("FAIL wb_after got=%b/%h exp=0/a5", commit_valid, rdata1); end
   endtask
   task automatic test_masked_flags();
      checks++; if (flags !== 4'h0) begin failures++; $display("FAIL mf_initial got=%h exp=0", flags); end
      drive(1'b1, 8'h00, 4'b1111, 4'b1000, 2'd0, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      #1;
      checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL mf_bypass got=%b exp=0010", flags); end
      tick();
      checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL mf_commit got=%b exp=0010", flags); end
   endtask
   task automatic test_back_to_back();
      int pulses = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(i + 1), 4'h0, 4'h0, 2'(i), 1'b1);
         #1;
         checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.in_ready); end
         if (commit_valid === 1'b1) pulses++;
         tick();
      end
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      #1;
      if (commit_valid === 1'b1) pulses++;
      tick();
      checks++; if (pulses !== 4) begin failures++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
      for (int i = 0; i < 4; i++) begin
         rs1 = 2'(i);
         #1;
         checks++; if (rdata1 !== 8'(i + 1)) begin failures++; $display("FAIL b2b_rf r%0d got=%h exp=%h", i, rdata1, 8'(i + 1)); end
      end
   endtask
   task automatic test_stall();
      drive(1'b1, 8'h77, 4'h0, 4'h0, 2'd3, 1'b1);
      tick();
      drive(1'b1, 8'h99, 4'h0, 4'h0, 2'd0, 1'b1);
      wb_stall = 1'b1;
      rs1 = 2'd3;
      rs2 = 2'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.in_ready !== 1'b0 || commit_valid !== 1'b0) begin
            failures++; $display("FAIL stall_hold c%0d got=%b/%b exp=0/0", i, bus.in_ready, commit_valid); end
         checks++; if (rdata1 !== 8'h77 || rdata2 !== 8'h01) begin
            failures++; $display("FAIL stall_bypass c%0d got=%h/%h exp=77/01", i, rdata1, rdata2); end
         tick();
      end
      wb_stall = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1 || commit_valid !== 1'b1 || commit_data !== 8'h77) begin
         failures++; $display("FAIL stall_release got=%b/%b/%h exp=1/1/77", bus.in_ready, commit_valid, commit_data); end
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      #1;
      checks++; if (rdata2 !== 8'h99 || commit_rd !== 2'd0 || rdata1 !== 8'h77) begin
         failures++; $display("FAIL stall_newentry got=%h/%0d/%h exp=99/0/77", rdata2, commit_rd, rdata1); end
      tick();
   endtask
   task automatic test_waw();
      rs1 = 2'd1;
      drive(1'b1, 8'h10, 4'h0, 4'h0, 2'd1, 1'b1);
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      tick();
      checks++; if (rdata1 !== 8'h10) begin failures++; $display("FAIL waw_first got=%h exp=10", rdata1); end
      drive(1'b1, 8'h20, 4'h0, 4'h0, 2'd1, 1'b1);
      tick();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      #1;
      checks++; if (rdata1 !== 8'h20) begin failures++; $display("FAIL waw_pending got=%h exp=20", rdata1); end
      tick();
      checks++; if (rdata1 !== 8'h20) begin failures++; $display("FAIL waw_commit got=%h exp=20", rdata1); end
   endtask
   task automatic test_random();
      logic [3:0] ef;
      logic       rdy;
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
         wb_stall = ($urandom_range(0, 3) == 0);
         rs1 = 2'($urandom);
         rs2 = 2'($urandom);
         #1;
         ef = exp_fl();
         rdy = pend.size() == 0 || !wb_stall;
         checks++; if (bus.in_ready !== rdy || commit_valid !== (pend.size() != 0 && !wb_stall)) begin
            failures++; $display("FAIL rnd_hs n=%0d got=%b/%b exp=%b/%b", n, bus.in_ready, commit_valid, rdy, pend.size() != 0 && !wb_stall); end
         checks++; if (rdata1 !== exp_rd(rs1) || rdata2 !== exp_rd(rs2)) begin
            failures++; $display("FAIL rnd_rdata n=%0d got=%h/%h exp=%h/%h", n, rdata1, rdata2, exp_rd(rs1), exp_rd(rs2)); end
         checks++; if (flags !== ef) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, flags, ef); end
         if (pend.size() != 0 && !wb_stall) begin
            checks++; if (commit_rd !== pend[0].rd || commit_data !== pend[0].data) begin
               failures++; $display("FAIL rnd_trace n=%0d got=%0d/%h exp=%0d/%h", n, commit_rd, commit_data, pend[0].rd, pend[0].data); end
         end
         tick();
      end
      wb_stall = 1'b0;
   endtask
   initial begin
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      model_reset();
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      test_reset();
      test_write_bypass();
      test_masked_flags();
      test_back_to_back();
      test_stall();
      test_waw();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
